// File: rtl/fifo_pkg.sv
// Shared sizing for the FIFO: data width, depth, pointer and counter widths,
// and default almost-full / almost-empty thresholds. Used by the memory and
// by the control block so both agree on the geometry.
package fifo_pkg;

  localparam int DATA_SIZE = 8;
  localparam int MAIN_SIZE = 6;
  localparam int PTR_SIZE  = 6;
  localparam int CNT_SIZE  = 4;
  localparam int AF_LVL    = 4;
  localparam int AE_LVL    = 1;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping address counter for the FIFO. Advances by one when en is high
// and wraps from MAIN_SIZE-1 back to 0, so depths that are not a power of
// two address only the entries that exist. Used for both read and write side.
module fifo_ptr #(
  parameter int MAIN_SIZE = fifo_pkg::MAIN_SIZE,
  parameter int PTR_SIZE  = fifo_pkg::PTR_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic [PTR_SIZE-1:0] ptr
);

  localparam logic [PTR_SIZE-1:0] LAST = PTR_SIZE'(MAIN_SIZE - 1);

  // Pointer register: clears asynchronously, steps with wrap on enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == LAST) ptr <= '0;
      else             ptr <= ptr + PTR_SIZE'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: pointers, occupancy count and status flags for an
// external MAIN_SIZE-entry memory.
// Optional feature: define FIFO_CTRL_ERR_EN to add the sticky overflow and
// underflow outputs; without it those ports and their logic do not exist.
//
// Request semantics: push and pop are requests that are accepted only when
// the FIFO can honour them (push while not full, pop while not empty). An
// accepted request drives its memory strobe in the same cycle and takes
// effect at the next rising edge; a rejected request changes nothing.
`ifndef FIFO_CTRL
`define FIFO_CTRL

module fifo_ctrl #(
  parameter int MAIN_SIZE = fifo_pkg::MAIN_SIZE,
  parameter int PTR_SIZE  = fifo_pkg::PTR_SIZE,
  parameter int CNT_SIZE  = fifo_pkg::CNT_SIZE,
  parameter int AF_LVL    = fifo_pkg::AF_LVL,
  parameter int AE_LVL    = fifo_pkg::AE_LVL
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  output logic                mem_write,
  output logic                mem_read,
  output logic [PTR_SIZE-1:0] wr_ptr,
  output logic [PTR_SIZE-1:0] rd_ptr,
  output logic [CNT_SIZE-1:0] count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
`ifdef FIFO_CTRL_ERR_EN
  output logic                overflow,
  output logic                underflow,
`endif
  output logic                almost_empty
);

  localparam logic [CNT_SIZE-1:0] CNT_MAX = CNT_SIZE'(MAIN_SIZE);
  localparam logic [CNT_SIZE-1:0] CNT_AF  = CNT_SIZE'(AF_LVL);
  localparam logic [CNT_SIZE-1:0] CNT_AE  = CNT_SIZE'(AE_LVL);

  logic                push_ok;
  logic                pop_ok;
  logic [CNT_SIZE-1:0] count_nxt;

  // Acceptance decode; reset gates the strobes because the flags alone
  // would still let a push through while reset is held low.
  always_comb begin
    push_ok   = push & ~full  & reset;
    pop_ok    = pop  & ~empty & reset;
    mem_write = push_ok;
    mem_read  = pop_ok;
  end

  // Next occupancy: simultaneous accepted push and pop cancel out.
  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CNT_SIZE'(1);
      2'b01:   count_nxt = count - CNT_SIZE'(1);
      default: count_nxt = count;
    endcase
  end

  // Count and flags are registered together so they never disagree.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count        <= count_nxt;
      full         <= (count_nxt == CNT_MAX);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CNT_AF);
      almost_empty <= (count_nxt <= CNT_AE);
    end
  end

  fifo_ptr #(
    .MAIN_SIZE (MAIN_SIZE),
    .PTR_SIZE  (PTR_SIZE)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (push_ok),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(
    .MAIN_SIZE (MAIN_SIZE),
    .PTR_SIZE  (PTR_SIZE)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (pop_ok),
    .ptr   (rd_ptr)
  );

`ifdef FIFO_CTRL_ERR_EN
  // Sticky error capture: a push refused for fullness (not rescued by a
  // same-cycle pop) or any pop while empty latches until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full & ~pop_ok) overflow  <= 1'b1;
      if (pop & empty)           underflow <= 1'b1;
    end
  end
`endif

endmodule

`endif

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: directed scenarios followed by random traffic,
// all checked against a queue-based model of the FIFO contents. A small
// array stands in for the data memory so lost or reordered entries show up.
module tb_fifo_ctrl;

  localparam int MAIN = 6;
  localparam int PW   = 6;
  localparam int CW   = 4;
  localparam int AF   = 4;
  localparam int AE   = 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic          mem_write;
  logic          mem_read;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
`ifdef FIFO_CTRL_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
`ifdef FIFO_CTRL_ERR_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .almost_empty (almost_empty)
  );

  // ---------------- reference model ----------------
  logic [7:0]    exp_q[$];    // data tokens in FIFO order
  int            addr_q[$];   // address each token was written to
  int            m_wr;        // next write address
  logic [7:0]    seq;         // next data token
  logic          m_ovf;
  logic          m_unf;
  logic [7:0]    tb_mem [64];

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_rd();
    return (addr_q.size() > 0) ? addr_q[0] : m_wr;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    addr_q.delete();
    m_wr  = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Registered state compared against the model.
  task automatic check_state(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".count"},        32'(count),        32'(n));
    check({tag, ".full"},         32'(full),         32'(n == MAIN));
    check({tag, ".empty"},        32'(empty),        32'(n == 0));
    check({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    check({tag, ".wr_ptr"},       32'(wr_ptr),       32'(m_wr));
    check({tag, ".rd_ptr"},       32'(rd_ptr),       32'(exp_rd()));
`ifdef FIFO_CTRL_ERR_EN
    check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    check({tag, ".underflow"},    32'(underflow),    32'(m_unf));
`endif
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input string tag, input logic p, input logic po);
    logic p_ok;
    logic po_ok;
    push = p;
    pop  = po;
    #1;
    p_ok  = p  && (exp_q.size() < MAIN);
    po_ok = po && (exp_q.size() > 0);
    check({tag, ".mem_write"}, 32'(mem_write), 32'(p_ok));
    check({tag, ".mem_read"},  32'(mem_read),  32'(po_ok));
    check({tag, ".wr_ptr_req"}, 32'(wr_ptr), 32'(m_wr));
    check({tag, ".rd_ptr_req"}, 32'(rd_ptr), 32'(exp_rd()));
    if (po_ok) check({tag, ".rd_data"}, 32'(tb_mem[rd_ptr]), 32'(exp_q[0]));
    if (mem_write) tb_mem[wr_ptr] = seq;
    @(posedge clk);
    #1;
    if (p && (exp_q.size() == MAIN) && !po_ok) m_ovf = 1'b1;
    if (po && (exp_q.size() == 0))             m_unf = 1'b1;
    if (po_ok) begin
      void'(exp_q.pop_front());
      void'(addr_q.pop_front());
    end
    if (p_ok) begin
      exp_q.push_back(seq);
      addr_q.push_back(m_wr);
      m_wr = (m_wr + 1) % MAIN;
    end
    seq  = seq + 8'd1;
    push = 1'b0;
    pop  = 1'b0;
    check_state(tag);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    seq         = 8'd1;
    for (int i = 0; i < 64; i++) tb_mem[i] = 8'h00;
    model_reset();
    reset = 1'b0;
    push  = 1'b1;   // strobes must stay low while reset is held
    pop   = 1'b1;
    #12;
    check("rst.mem_write", 32'(mem_write), 32'd0);
    check("rst.mem_read",  32'(mem_read),  32'd0);
    push = 1'b0;
    pop  = 1'b0;
    check_state("rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Fill from empty: wr_ptr walks 0..5 then wraps to 0.
    for (int i = 0; i < MAIN; i++) begin
      step("fill", 1'b1, 1'b0);
      if (i == AF - 1) check("fill.af_at_4", 32'(almost_full), 32'd1);
    end
    check("fill.full_at_6", 32'(full), 32'd1);
    check("fill.wrap", 32'(wr_ptr), 32'd0);

    // Push while full is refused.
    step("push_full", 1'b1, 1'b0);
    check("push_full.count", 32'(count), 32'd6);

    // Push+pop while full: only the pop is taken.
    step("pp_full", 1'b1, 1'b1);
    check("pp_full.count", 32'(count), 32'd5);

    // Drain to 3, then push+pop together.
    step("drain", 1'b0, 1'b1);
    step("drain", 1'b0, 1'b1);
    step("pp_mid", 1'b1, 1'b1);
    check("pp_mid.count", 32'(count), 32'd3);

    // Reset mid-stream with count=3: clears immediately, no clock needed.
    reset = 1'b0;
    push  = 1'b1;
    #1;
    check("midrst.count",     32'(count),     32'd0);
    check("midrst.wr_ptr",    32'(wr_ptr),    32'd0);
    check("midrst.rd_ptr",    32'(rd_ptr),    32'd0);
    check("midrst.empty",     32'(empty),     32'd1);
    check("midrst.mem_write", 32'(mem_write), 32'd0);
    push = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_state("midrst");

    // Push+pop while empty: only the push is taken.
    step("pp_empty", 1'b1, 1'b1);
    check("pp_empty.count", 32'(count), 32'd1);

    // Pop to empty, then pop while empty is refused.
    step("pop_last", 1'b0, 1'b1);
    step("pop_empty", 1'b0, 1'b1);

    // Random interleaved traffic.
    for (int i = 0; i < 20; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Drain whatever is left so every stored token is read back.
    for (int i = 0; i < MAIN; i++) step("final_drain", 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter MAIN_SIZE, default 6: number of memory entries.
REQ-002 SHALL have parameter PTR_SIZE, default 6: pointer width, matching the 6x8 memory address width.
REQ-003 SHALL have parameter CNT_SIZE, default 4: occupancy counter width, able to hold 0..MAIN_SIZE.
REQ-004 SHALL have parameter AF_LVL, default 4: almost-full threshold.
REQ-005 SHALL have parameter AE_LVL, default 1: almost-empty threshold.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port push, input, 1 bit: write request from upstream.
REQ-009 SHALL have port pop, input, 1 bit: read request from downstream.
REQ-010 SHALL have port mem_write, output, 1 bit: write strobe to the memory.
REQ-011 SHALL have port mem_read, output, 1 bit: read strobe to the memory.
REQ-012 SHALL have port wr_ptr, output, PTR_SIZE bits: memory write address.
REQ-013 SHALL have port rd_ptr, output, PTR_SIZE bits: memory read address.
REQ-014 SHALL have port count, output, CNT_SIZE bits: current occupancy.
REQ-015 SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit: status flags.
REQ-016 SHALL have ports overflow and underflow, each output, 1 bit: sticky error flags, present only with FIFO_CTRL_ERR_EN.

Function
REQ-017 SHALL accept a push (push_ok) when push=1 and full=0.
REQ-018 SHALL accept a pop (pop_ok) when pop=1 and empty=0.
REQ-019 SHALL drive mem_write=push_ok and mem_read=pop_ok combinationally, in the same cycle as the request, with zero latency.
REQ-020 SHALL present rd_ptr during the pop cycle so that read data is valid in that same cycle.
REQ-021 SHALL present wr_ptr during the push cycle; the memory captures the data at that clock edge.
REQ-022 SHALL advance wr_ptr by 1 on each push_ok at the clock edge, wrapping from MAIN_SIZE-1 to 0 (non-power-of-two wrap).
REQ-023 SHALL advance rd_ptr by 1 on each pop_ok at the clock edge, with the same wrap rule.
REQ-024 SHALL update count as +1 for push_ok only, -1 for pop_ok only, and unchanged for both or neither.
REQ-025 SHALL register count and update every flag in the same clock edge as count.
REQ-026 SHALL decode full = (count==MAIN_SIZE) and empty = (count==0).
REQ-027 SHALL decode almost_full = (count>=AF_LVL) and almost_empty = (count<=AE_LVL).
REQ-028 SHALL, when full with push=1 and pop=1, accept only the pop; count goes to MAIN_SIZE-1.
REQ-029 SHALL, when empty with push=1 and pop=1, accept only the push; count goes to 1, and mem_read=0.
REQ-030 SHALL ignore a rejected push or pop entirely: pointers, count and memory strobes stay unchanged.
REQ-031 SHALL never let count exceed MAIN_SIZE or drop below 0.

Reset
REQ-032 SHALL, on reset=0 (asynchronous), immediately set wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0 and underflow=0.
REQ-033 SHALL force mem_write=0 and mem_read=0 while reset=0.
REQ-034 SHALL, on reset mid-operation, discard all stored occupancy; no entry is recoverable afterwards.
REQ-035 SHALL accept the first request on the first rising edge after reset deassertion.

Configuration
REQ-036 SHALL, with FIFO_CTRL_ERR_EN defined, set overflow on push=1 while full=0 is false (i.e. full=1) and pop_ok=0.
REQ-037 SHALL, with FIFO_CTRL_ERR_EN defined, set underflow on pop=1 while empty=1.
REQ-038 SHALL, with FIFO_CTRL_ERR_EN defined, hold overflow and underflow until reset.
REQ-039 SHALL, without FIFO_CTRL_ERR_EN, omit the overflow and underflow ports and logic; all other behaviour is identical.

Structure
REQ-040 SHALL place DATA_SIZE=8, MAIN_SIZE=6, PTR_SIZE and CNT_SIZE defaults in shared package fifo_pkg, reused by the memory and the top level.
REQ-041 SHALL implement both pointers with one sub-module, fifo_ptr: a wrapping counter with an enable input and a MAIN_SIZE-1 wrap limit, instantiated twice.
REQ-042 SHALL be wrapped in an include guard FIFO_CTRL.

Verification
REQ-043 SHALL be verified: reset asserted mid-stream with count=3 -> count=0, ptrs=0, empty=1 immediately, before any clock edge.
REQ-044 SHALL be verified: 6 pushes from empty -> wr_ptr 0..5 then 0; full=1 after the 6th; almost_full=1 after the 4th.
REQ-045 SHALL be verified: a 7th push while full -> mem_write=0 and count stays 6; overflow=1 if FIFO_CTRL_ERR_EN.
REQ-046 SHALL be verified: push+pop together at count=3 -> count stays 3, both pointers advance, and both strobes are 1.
REQ-047 SHALL be verified: push+pop at empty -> mem_write=1, mem_read=0, count=1; push+pop at full -> mem_write=0, mem_read=1, count=5.
REQ-048 SHALL be verified: 20 random interleaved requests checked against a reference queue model -> rd_ptr order matches wr_ptr order and no entry is lost.
